// File: rtl/ahb_burst_master.sv
// AHB-Lite INCR burst initiator for the DDR3 bridge slave port.
// Turns client command/write-data streams into pipelined bursts and returns read data in order.
module ahb_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic [1:0]        HTRANS,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP,
    input  logic [DATA_W-1:0] HRDATA
);

    // state      | meaning
    // S_WAIT_INIT| bus idle until DDR3 init completes (entered only from reset)
    // S_IDLE     | ready for a command
    // S_ISSUE    | presenting address phases of the burst
    // S_DRAIN    | all addresses accepted, waiting on the last data phase
    // S_ERR      | second cycle of an ERROR response, bus forced IDLE
    // S_DONE     | done/err pulse visible, cmd_ready still low
    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_ERR,
        S_DONE
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W:0]      rem_q, rem_d;
    logic                first_q, first_d;
    logic                write_q, write_d;
    logic                dp_q, dp_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                beat_rdy;
    logic                seq_ok;
    logic                resp_err;
    logic [1:0]          htrans_c;
    logic                cmd_ready_c;
    logic                wd_ready_c;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_WAIT_INIT;
            addr_q     <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            write_q    <= 1'b0;
            dp_q       <= 1'b0;
            hwdata_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            write_q    <= write_d;
            dp_q       <= dp_d;
            hwdata_q   <= hwdata_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // A beat may go out unless it is a write whose data word has not arrived yet.
    assign beat_rdy = !write_q || wd_valid;
    // Crossing into a new 1 KB page restarts the burst with NONSEQ.
    assign seq_ok   = !first_q && (addr_q[9:0] != 10'd0);
    assign resp_err = dp_q && !HREADY && (HRESP == RESP_ERR);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        first_d     = first_q;
        write_d     = write_q;
        dp_d        = dp_q;
        hwdata_d    = hwdata_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        htrans_c    = TR_IDLE;
        cmd_ready_c = 1'b0;
        wd_ready_c  = 1'b0;

        case (state_q)
            S_WAIT_INIT: begin
                if (init_done) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                cmd_ready_c = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ~ADDR_W'(3);
                    rem_d   = {1'b0, cmd_len} + (LEN_W + 1)'(1);
                    write_d = cmd_write;
                    first_d = 1'b1;
                    dp_d    = 1'b0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (beat_rdy) begin
                    htrans_c = seq_ok ? TR_SEQ : TR_NONSEQ;
                end else begin
                    htrans_c = first_q ? TR_IDLE : TR_BUSY;
                end
                wd_ready_c = write_q && wd_valid && HREADY;

                if (resp_err) begin
                    state_d = S_ERR;
                end else if (HREADY) begin
                    if (dp_q && !write_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = HRDATA;
                    end
                    dp_d = beat_rdy;
                    if (beat_rdy) begin
                        addr_d  = addr_q + ADDR_W'(4);
                        rem_d   = rem_q - (LEN_W + 1)'(1);
                        first_d = 1'b0;
                        if (write_q) begin
                            hwdata_d = wd_data;
                        end
                        if (rem_q == (LEN_W + 1)'(1)) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end

            S_DRAIN: begin
                if (resp_err) begin
                    state_d = S_ERR;
                end else if (HREADY) begin
                    if (!write_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = HRDATA;
                    end
                    dp_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_ERR: begin
                if (HREADY) begin
                    dp_d    = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_WAIT_INIT;
            end
        endcase
    end

    assign HTRANS    = htrans_c;
    assign HADDR     = addr_q;
    assign HWRITE    = write_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b001;
    assign HWDATA    = hwdata_q;
    assign cmd_ready = cmd_ready_c;
    assign wd_ready  = wd_ready_c;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: per-cycle vector table plus init and reset sequences.
module tb_ahb_burst_master;

    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] B = 2'b01;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] S = 2'b11;

    localparam logic [31:0] WA = 32'h01CA1056;
    localparam logic [31:0] W0 = 32'hAAAA0000, W1 = 32'hAAAA0001, W2 = 32'hAAAA0002, W3 = 32'hAAAA0003;
    localparam logic [31:0] D0 = 32'hD0000000, D1 = 32'hD0000001, D2 = 32'hD0000002, D3 = 32'hD0000003;
    localparam logic [31:0] E0 = 32'hE0000000, E1 = 32'hE0000001, E2 = 32'hE0000002, E3 = 32'hE0000003;
    localparam logic [31:0] F0 = 32'hF0000000;
    localparam logic [31:0] B0 = 32'hBB000000, B1 = 32'hBB000001;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        init_done = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        wd_valid = 1'b0;
    logic        wd_ready;
    logic [31:0] wd_data = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic [1:0]  HRESP = 2'b00;
    logic [31:0] HRDATA = '0;

    ahb_burst_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .init_done (init_done),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        cv;
        logic        cw;
        logic [31:0] ca;
        logic [3:0]  cl;
        logic        wv;
        logic [31:0] wd;
        logic        hr;
        logic        he;
        logic [31:0] hrd;
        logic        e_crdy;
        logic [1:0]  e_tr;
        logic [31:0] e_addr;
        logic        e_wrdy;
        logic        e_hwc;
        logic [31:0] e_hw;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    logic cur_write = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic cv, input logic cw, input logic [31:0] ca, input logic [3:0] cl,
                       input logic wv, input logic [31:0] wd, input logic hr, input logic he, input logic [31:0] hrd,
                       input logic e_crdy, input logic [1:0] e_tr, input logic [31:0] e_addr, input logic e_wrdy,
                       input logic e_hwc, input logic [31:0] e_hw, input logic e_rv, input logic [31:0] e_rd,
                       input logic e_done, input logic e_err);
        vec_t v;
        v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wd;
        v.hr = hr; v.he = he; v.hrd = hrd;
        v.e_crdy = e_crdy; v.e_tr = e_tr; v.e_addr = e_addr; v.e_wrdy = e_wrdy;
        v.e_hwc = e_hwc; v.e_hw = e_hw; v.e_rv = e_rv; v.e_rd = e_rd;
        v.e_done = e_done; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " HTRANS"}, 32'(HTRANS), 32'h0);
        chk({tag, " HADDR"}, HADDR, 32'h0);
        chk({tag, " HWRITE"}, 32'(HWRITE), 32'h0);
        chk({tag, " HWDATA"}, HWDATA, 32'h0);
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'h0);
        chk({tag, " wd_ready"}, 32'(wd_ready), 32'h0);
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'h0);
        chk({tag, " rd_data"}, rd_data, 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
        chk({tag, " err"}, 32'(err), 32'h0);
        chk({tag, " HSIZE"}, 32'(HSIZE), 32'h2);
        chk({tag, " HBURST"}, 32'(HBURST), 32'h1);
    endtask

    initial begin
        // cv cw ca      cl  wv wd  hr he hrd   crdy tr addr     wrdy hwc hw  rv rd  done err
        // single write, zero wait
        row(1, 1, 'h100, 0,  1, WA, 1, 0, 0,    1, I, 0,       0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  1, WA, 1, 0, 0,    0, N, 'h100,   1,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, I, 0,       0,   1, WA, 0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, I, 0,       0,   1, WA, 0, 0,  1, 0);
        // 4-beat read, 2-cycle stall while 0x208 is presented
        row(1, 0, 'h200, 3,  0, 0,  1, 0, 0,    1, I, 0,       0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, N, 'h200,   0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, D0,   0, S, 'h204,   0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  0, 0, 'hBAD,0, S, 'h208,   0,   0, 0,  1, D0, 0, 0);
        row(0, 0, 0,     0,  0, 0,  0, 0, 'hBAD,0, S, 'h208,   0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, D1,   0, S, 'h208,   0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, D2,   0, S, 'h20C,   0,   0, 0,  1, D1, 0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, D3,   0, I, 0,       0,   0, 0,  1, D2, 0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, I, 0,       0,   0, 0,  1, D3, 1, 0);
        // 4-beat write, data missing 3 cycles after the first beat
        row(1, 1, 'h300, 3,  1, W0, 1, 0, 0,    1, I, 0,       0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  1, W0, 1, 0, 0,    0, N, 'h300,   1,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, B, 'h304,   0,   1, W0, 0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, B, 'h304,   0,   1, W0, 0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, B, 'h304,   0,   1, W0, 0, 0,  0, 0);
        row(0, 0, 0,     0,  1, W1, 1, 0, 0,    0, S, 'h304,   1,   1, W0, 0, 0,  0, 0);
        row(0, 0, 0,     0,  1, W2, 1, 0, 0,    0, S, 'h308,   1,   1, W1, 0, 0,  0, 0);
        row(0, 0, 0,     0,  1, W3, 1, 0, 0,    0, S, 'h30C,   1,   1, W2, 0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, I, 0,       0,   1, W3, 0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, I, 0,       0,   1, W3, 0, 0,  1, 0);
        // read across the 1 KB page
        row(1, 0, 'h3F8, 3,  0, 0,  1, 0, 0,    1, I, 0,       0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, N, 'h3F8,   0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, E0,   0, S, 'h3FC,   0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, E1,   0, N, 'h400,   0,   0, 0,  1, E0, 0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, E2,   0, S, 'h404,   0,   0, 0,  1, E1, 0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, E3,   0, I, 0,       0,   0, 0,  1, E2, 0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, I, 0,       0,   0, 0,  1, E3, 1, 0);
        // ERROR on the second beat of a 4-beat read
        row(1, 0, 'h502, 3,  0, 0,  1, 0, 0,    1, I, 0,       0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, N, 'h500,   0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, F0,   0, S, 'h504,   0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  0, 1, 0,    0, S, 'h508,   0,   0, 0,  1, F0, 0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 1, 0,    0, I, 0,       0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, I, 0,       0,   0, 0,  0, 0,  1, 1);
        // following 2-beat write, first word late
        row(1, 1, 'h600, 1,  0, 0,  1, 0, 0,    1, I, 0,       0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, I, 0,       0,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  1, B0, 1, 0, 0,    0, N, 'h600,   1,   0, 0,  0, 0,  0, 0);
        row(0, 0, 0,     0,  1, B1, 1, 0, 0,    0, S, 'h604,   1,   1, B0, 0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, I, 0,       0,   1, B1, 0, 0,  0, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    0, I, 0,       0,   1, B1, 0, 0,  1, 0);
        row(0, 0, 0,     0,  0, 0,  1, 0, 0,    1, I, 0,       0,   0, 0,  0, 0,  0, 0);

        // reset values while held in reset
        #2;
        chk_reset_values("reset");
        #20;
        @(negedge HCLK);
        HRESETn   = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h80;

        // init_done low: nothing leaves the block
        for (int c = 0; c < 20; c++) begin
            @(posedge HCLK); #1;
            @(negedge HCLK);
            chk($sformatf("wait_init%0d HTRANS", c), 32'(HTRANS), 32'h0);
            chk($sformatf("wait_init%0d cmd_ready", c), 32'(cmd_ready), 32'h0);
        end
        @(posedge HCLK); #1;
        init_done = 1'b1;
        cmd_valid = 1'b0;
        @(negedge HCLK);
        chk("init_rise cmd_ready same cycle", 32'(cmd_ready), 32'h0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("init_rise cmd_ready next cycle", 32'(cmd_ready), 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge HCLK); #1;
            cmd_valid = vecs[i].cv;
            cmd_write = vecs[i].cw;
            cmd_addr  = vecs[i].ca;
            cmd_len   = vecs[i].cl;
            wd_valid  = vecs[i].wv;
            wd_data   = vecs[i].wd;
            HREADY    = vecs[i].hr;
            HRESP     = {1'b0, vecs[i].he};
            HRDATA    = vecs[i].hrd;
            if (vecs[i].cv && vecs[i].e_crdy) cur_write = vecs[i].cw;
            @(negedge HCLK);
            chk($sformatf("row%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_crdy));
            chk($sformatf("row%0d HTRANS", i), 32'(HTRANS), 32'(vecs[i].e_tr));
            chk($sformatf("row%0d wd_ready", i), 32'(wd_ready), 32'(vecs[i].e_wrdy));
            chk($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rv));
            chk($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("row%0d err", i), 32'(err), 32'(vecs[i].e_err));
            if (vecs[i].e_tr != I) begin
                chk($sformatf("row%0d HADDR", i), HADDR, vecs[i].e_addr);
                chk($sformatf("row%0d HWRITE", i), 32'(HWRITE), 32'(cur_write));
            end
            if (vecs[i].e_hwc) chk($sformatf("row%0d HWDATA", i), HWDATA, vecs[i].e_hw);
            if (vecs[i].e_rv)  chk($sformatf("row%0d rd_data", i), rd_data, vecs[i].e_rd);
        end

        // reset in the middle of a read burst
        @(posedge HCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h700; cmd_len = 4'd3;
        HREADY = 1'b1; HRESP = 2'b00; wd_valid = 1'b0;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        @(negedge HCLK);
        chk("midrst NONSEQ", 32'(HTRANS), 32'(N));
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("midrst SEQ", 32'(HTRANS), 32'(S));
        chk("midrst HADDR", HADDR, 32'h704);
        #2;
        HRESETn = 1'b0;
        #1;
        chk_reset_values("midrst");
        init_done = 1'b0;
        @(posedge HCLK); #1;
        HRESETn   = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_len = 4'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge HCLK);
            chk($sformatf("post_rst%0d cmd_ready", c), 32'(cmd_ready), 32'h0);
            chk($sformatf("post_rst%0d HTRANS", c), 32'(HTRANS), 32'h0);
            @(posedge HCLK); #1;
        end
        init_done = 1'b1;
        @(negedge HCLK);
        chk("post_rst init cmd_ready same cycle", 32'(cmd_ready), 32'h0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("post_rst cmd_ready", 32'(cmd_ready), 32'h1);
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        @(negedge HCLK);
        chk("post_rst NONSEQ", 32'(HTRANS), 32'(N));
        chk("post_rst HADDR", HADDR, 32'h40);
        @(posedge HCLK); #1;
        HRDATA = 32'h5A5A5A5A;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("post_rst rd_valid", 32'(rd_valid), 32'h1);
        chk("post_rst rd_data", rd_data, 32'h5A5A5A5A);
        chk("post_rst done", 32'(done), 32'h1);
        chk("post_rst err", 32'(err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
